// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Purpose : Shared definitions for the PE job controller: controller state
//           encoding and the default operand / counter widths.
// Contents: DATA_W_DEF, CNT_W_DEF, STALL_W, state_e.
// Optional feature macro used by pe_ctrl: PE_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int STALL_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage : pe_ctrl_pkg

// File: rtl/pe_ctrl.sv
// -----------------------------------------------------------------------------
// pe_ctrl
// Purpose : Sequences one multiply-accumulate PE through a job of cfg_outs
//           outputs, each the sum of cfg_taps operand products. Per output:
//           CLEAR (accumulator clear) -> MAC (operand beats) -> WAIT (PE
//           result) -> OUT (result handshake).
// Optional: define PE_CTRL_PERF_EN to add the stall_cnt output.
//
// Ports
//   clk, reset               : clock, asynchronous active-high reset
//   start, cfg_taps, cfg_outs: job request and its shape (0 means 1)
//   in_valid/in_ready/in_ifm/in_wgt : operand stream into the controller
//   pe_ifm/pe_wgt/pe_en/pe_finish   : drive to the PE
//   pe_valid/pe_ofm                 : result from the PE
//   ofm_valid/ofm_ready/ofm_data/ofm_idx : result stream out
//   busy, done, tap_idx       : status and operand-buffer address
//   stall_cnt (PE_CTRL_PERF_EN only) : saturating stall counter
//
// Handshake: a transfer happens in a cycle where valid and ready are both 1;
// a valid source holds its data until that cycle. in_ready depends only on
// state, ofm_valid only on state, so neither depends on the partner signal.
// -----------------------------------------------------------------------------
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_taps,
  input  logic [CNT_W-1:0]  cfg_outs,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ifm,
  input  logic [DATA_W-1:0] in_wgt,
  output logic [DATA_W-1:0] pe_ifm,
  output logic [DATA_W-1:0] pe_wgt,
  output logic              pe_en,
  output logic              pe_finish,
  input  logic              pe_valid,
  input  logic [DATA_W-1:0] pe_ofm,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [DATA_W-1:0] ofm_data,
  output logic [CNT_W-1:0]  ofm_idx,
  output logic              busy,
  output logic              done,
`ifdef PE_CTRL_PERF_EN
  output logic [STALL_W-1:0] stall_cnt,
`endif
  output logic [CNT_W-1:0]  tap_idx
);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_taps;
  logic [CNT_W-1:0]   r_outs;
  logic [CNT_W-1:0]   r_tap_idx;
  logic [CNT_W-1:0]   r_ofm_idx;
  logic [DATA_W-1:0]  r_ofm_data;
  logic               r_done;

  logic               w_beat;
  logic               w_last_tap;
  logic               w_last_out;
  logic               w_out_hs;

  assign w_beat     = (r_state == MAC) && in_valid;
  // Compare against taps-1 rather than counting to taps so that taps equal to
  // the counter maximum never needs a wrapped index.
  assign w_last_tap = (r_tap_idx == (r_taps - CNT_W'(1)));
  assign w_last_out = (r_ofm_idx == (r_outs - CNT_W'(1)));
  assign w_out_hs   = (r_state == OUT) && ofm_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = MAC;
      MAC:     if (w_beat && w_last_tap) w_next = WAIT;
      WAIT:    if (pe_valid) w_next = OUT;
      OUT:     if (ofm_ready) w_next = w_last_out ? IDLE : CLEAR;
      default: w_next = IDLE;
    endcase
  end

  // Job configuration, counters and result holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taps     <= '0;
      r_outs     <= '0;
      r_tap_idx  <= '0;
      r_ofm_idx  <= '0;
      r_ofm_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_taps    <= (cfg_taps == '0) ? CNT_W'(1) : cfg_taps;
            r_outs    <= (cfg_outs == '0) ? CNT_W'(1) : cfg_outs;
            r_tap_idx <= '0;
            r_ofm_idx <= '0;
          end
        end
        MAC: begin
          if (w_beat) r_tap_idx <= r_tap_idx + CNT_W'(1);
        end
        WAIT: begin
          if (pe_valid) r_ofm_data <= pe_ofm;
        end
        OUT: begin
          if (w_out_hs) begin
            if (w_last_out) begin
              r_done <= 1'b1;
            end else begin
              r_ofm_idx <= r_ofm_idx + CNT_W'(1);
              r_tap_idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_stall;

  assign w_stall = ((r_state == MAC) && !in_valid) ||
                   ((r_state == OUT) && !ofm_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  // Operands are forced to zero outside beats: the PE adds its inputs every
  // cycle pe_en is low, so idle cycles must contribute nothing.
  assign pe_ifm    = w_beat ? in_ifm : '0;
  assign pe_wgt    = w_beat ? in_wgt : '0;
  assign pe_en     = (r_state == CLEAR);
  assign pe_finish = w_beat && w_last_tap;
  assign in_ready  = (r_state == MAC);
  assign ofm_valid = (r_state == OUT);
  assign ofm_data  = r_ofm_data;
  assign ofm_idx   = r_ofm_idx;
  assign tap_idx   = r_tap_idx;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule : pe_ctrl

// File: tb/tb_pe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_ctrl
// Purpose : Self-checking bench for pe_ctrl with a behavioural PE attached.
//           Expected sums come from the bench's own operand values; latency,
//           beat counts and output order come from the job shape.
// Optional: PE_CTRL_PERF_EN also checks stall_cnt.
// -----------------------------------------------------------------------------
module tb_pe_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  cfg_taps;
  logic [CNT_W-1:0]  cfg_outs;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_ifm;
  logic [DATA_W-1:0] in_wgt;
  logic [DATA_W-1:0] pe_ifm;
  logic [DATA_W-1:0] pe_wgt;
  logic              pe_en;
  logic              pe_finish;
  logic              pe_valid;
  logic [DATA_W-1:0] pe_ofm;
  logic              ofm_valid;
  logic              ofm_ready;
  logic [DATA_W-1:0] ofm_data;
  logic [CNT_W-1:0]  ofm_idx;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  tap_idx;
`ifdef PE_CTRL_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Operand stream for directed jobs; random operands when empty.
  logic [DATA_W-1:0] ifm_q[$];
  logic [DATA_W-1:0] wgt_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  pe_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_taps  (cfg_taps),
    .cfg_outs  (cfg_outs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ifm    (in_ifm),
    .in_wgt    (in_wgt),
    .pe_ifm    (pe_ifm),
    .pe_wgt    (pe_wgt),
    .pe_en     (pe_en),
    .pe_finish (pe_finish),
    .pe_valid  (pe_valid),
    .pe_ofm    (pe_ofm),
    .ofm_valid (ofm_valid),
    .ofm_ready (ofm_ready),
    .ofm_data  (ofm_data),
    .ofm_idx   (ofm_idx),
    .busy      (busy),
    .done      (done),
`ifdef PE_CTRL_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .tap_idx   (tap_idx)
  );

  // ---------------- behavioural PE ----------------
  // Clears on pe_en, otherwise accumulates every cycle; result is presented
  // the cycle after pe_finish.
  logic [DATA_W-1:0] pe_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_acc   <= '0;
      pe_valid <= 1'b0;
    end else begin
      if (pe_en) pe_acc <= '0;
      else       pe_acc <= pe_acc + DATA_W'(pe_ifm * pe_wgt);
      pe_valid <= pe_finish;
    end
  end
  assign pe_ofm = pe_acc;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_pe_en"},     32'(pe_en),     0);
    check({tag, "_pe_finish"}, 32'(pe_finish), 0);
    check({tag, "_pe_ifm"},    32'(pe_ifm),    0);
    check({tag, "_pe_wgt"},    32'(pe_wgt),    0);
    check({tag, "_ofm_valid"}, 32'(ofm_valid), 0);
    check({tag, "_ofm_data"},  32'(ofm_data),  0);
    check({tag, "_ofm_idx"},   32'(ofm_idx),   0);
    check({tag, "_tap_idx"},   32'(tap_idx),   0);
`ifdef PE_CTRL_PERF_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
  endtask

  // ---------------- job driver + reference model ----------------
  // Runs one job from IDLE to its done pulse. gap_pct/stall_pct are the
  // percentages of in_valid=0 / ofm_ready=0 cycles; force_stall holds
  // ofm_ready low for that many cycles at the start of every OUT.
  task automatic run_job(input int taps, input int outs, input int gap_pct,
                         input int stall_pct, input int force_stall,
                         input bit busy_start);
    int eff_t, eff_o, iter, beats, out_no, pe_en_cnt, stalls, hold;
    bit seen_done, beat;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] prod;
    eff_t = (taps == 0) ? 1 : taps;
    eff_o = (outs == 0) ? 1 : outs;
    iter = 0; beats = 0; out_no = 0; pe_en_cnt = 0; stalls = 0; hold = 0;
    seen_done = 1'b0; sum = '0;

    @(negedge clk);
    start = 1'b1; cfg_taps = CNT_W'(taps); cfg_outs = CNT_W'(outs);
    in_valid = 1'b0; ofm_ready = 1'b0;
    #1 check("idle_before_start", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    // Scramble cfg after the start so only the latched copy can matter.
    cfg_taps = CNT_W'($urandom_range(1, 9)); cfg_outs = CNT_W'($urandom_range(1, 9));

    while (!seen_done && iter < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      if (ifm_q.size() > 0) begin
        in_ifm = ifm_q[0]; in_wgt = wgt_q[0];
      end else begin
        in_ifm = DATA_W'($urandom); in_wgt = DATA_W'($urandom);
      end
      if (ofm_valid && hold < force_stall) begin
        ofm_ready = 1'b0; hold++;
      end else begin
        ofm_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      start = busy_start && busy && (iter % 4 == 2);
      if (start) cfg_taps = CNT_W'($urandom_range(1, 9));
      #1;

      if (done) begin
        seen_done = 1'b1;
        check("done_out_count", out_no, eff_o);
        check("done_busy", 32'(busy), 0);
        if (gap_pct == 0 && stall_pct == 0 && force_stall == 0)
          check("job_latency", iter, eff_o * (eff_t + 3));
`ifdef PE_CTRL_PERF_EN
        check("stall_cnt", 32'(stall_cnt), stalls);
`endif
      end else begin
        check("busy", 32'(busy), 1);
      end

      if (pe_en) pe_en_cnt++;
      beat = in_valid && in_ready;
      if (beat) begin
        prod = DATA_W'(in_ifm * in_wgt);
        check("tap_idx", 32'(tap_idx), beats);
        check("pe_ifm_beat", 32'(pe_ifm), 32'(in_ifm));
        check("pe_wgt_beat", 32'(pe_wgt), 32'(in_wgt));
        check("pe_finish_beat", 32'(pe_finish), 32'(beats == eff_t - 1));
        sum = sum + prod;
        beats++;
        if (ifm_q.size() > 0) begin
          void'(ifm_q.pop_front()); void'(wgt_q.pop_front());
        end
      end else begin
        check("pe_ops_idle", {pe_ifm, pe_wgt}, 0);
        check("pe_finish_idle", 32'(pe_finish), 0);
      end
      if (in_ready && !in_valid) stalls++;

      if (ofm_valid) begin
        check("ofm_data", 32'(ofm_data), 32'(sum));
        check("ofm_idx", 32'(ofm_idx), out_no);
        check("beats_per_out", beats, eff_t);
        check("pe_en_in_out", 32'(pe_en), 0);
        if (!ofm_ready) begin
          stalls++;
        end else begin
          out_no++; beats = 0; sum = '0; hold = 0;
        end
      end
      @(negedge clk);
      iter++;
    end

    check("done_seen", 32'(seen_done), 1);
    check("pe_en_cycles", pe_en_cnt, eff_o);
    in_valid = 1'b0; ofm_ready = 1'b0; start = 1'b0;
    #1;
    check("done_single_pulse", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
`ifdef PE_CTRL_PERF_EN
    check("stall_cnt_hold", 32'(stall_cnt), stalls);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; cfg_taps = '0; cfg_outs = '0;
    in_valid = 1'b0; in_ifm = '0; in_wgt = '0; ofm_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Three-tap single output with known operands: 2*3 + 1*4 + 5*1 = 15.
    ifm_q = '{8'd2, 8'd1, 8'd5};
    wgt_q = '{8'd3, 8'd4, 8'd1};
    run_job(3, 1, 0, 0, 0, 1'b0);
    check("known_sum_15", 32'(ofm_data), 15);

    // Two outputs with operand gaps mid-output.
    run_job(2, 2, 40, 0, 0, 1'b0);

    // Output consumer holds off five cycles on each result.
    run_job(2, 1, 0, 0, 5, 1'b0);

    // Zero configuration behaves as one tap, one output.
    run_job(0, 0, 0, 0, 0, 1'b0);

    // Reset in the middle of a four-tap job, after the first beat.
    @(negedge clk);
    start = 1'b1; cfg_taps = 8'd4; cfg_outs = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_ifm = 8'd7; in_wgt = 8'd9;
    @(negedge clk);
    @(negedge clk);
    #1 check("tap_before_reset", 32'(tap_idx), 1);
    #1 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    ifm_q = '{8'd3, 8'd4, 8'd5, 8'd6};
    wgt_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_job(4, 1, 0, 0, 0, 1'b0);
    check("post_reset_sum", 32'(ofm_data), 3 + 8 + 15 + 24);

    // Start pulses while busy must not disturb the running job.
    run_job(3, 2, 10, 10, 0, 1'b1);

    // Randomized job shapes with gaps and output stalls.
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 8), $urandom_range(1, 4), 20, 20, 0, 1'b0);

    // Largest tap count for an 8-bit counter.
    run_job(255, 1, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pe_ctrl
